// File: rtl/bsg_nasti_pkg.sv
// Shared NASTI encodings and the bsg request layout
// used by the client request and response paths.
package bsg_nasti_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_WRESP
  } state_e;

  localparam int REQ_ID_W   = 5;
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 64;

  typedef struct packed {
    logic                    write;
    logic [REQ_ID_W-1:0]     id;
    logic [REQ_ADDR_W-1:0]   addr;
    logic [REQ_DATA_W-1:0]   data;
    logic [REQ_DATA_W/8-1:0] mask;
    logic                    last;
  } req_s;

  function automatic int req_width(
    input int id_w,
    input int addr_w,
    input int data_w
  );
    return 2 + id_w + addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/bsg_nasti_burst_addr_gen.sv
// Burst address and beat counter; the address advances
// one beat per step unless the burst is FIXED.
module bsg_nasti_burst_addr_gen
  import bsg_nasti_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int len_width_p  = 8,
  parameter int data_width_p = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    step,
  input  logic [addr_width_p-1:0] load_addr,
  input  logic [len_width_p-1:0]  load_len,
  input  logic [1:0]              load_burst,
  output logic [addr_width_p-1:0] addr,
  output logic [len_width_p-1:0]  count,
  output logic                    last
);

  localparam logic [addr_width_p-1:0] stride_lp =
    addr_width_p'(data_width_p / 8);

  burst_e burst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      count <= '0;
      burst <= BURST_FIXED;
    end else if (load) begin
      addr  <= load_addr;
      count <= load_len;
      burst <= burst_e'(load_burst);
    end else if (step) begin
      // WRAP is treated as INCR
      if (burst != BURST_FIXED)
        addr <= addr + stride_lp;
      if (count != '0)
        count <= count - len_width_p'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/bsg_nasti_client_req.sv
// NASTI AR/AW/W to bsg valid/yumi request serializer
// with B response generation.
module bsg_nasti_client_req
  import bsg_nasti_pkg::*;
#(
  parameter int id_width_p   = 5,
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64,
  parameter int len_width_p  = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      nasti_ar_valid_i,
  input  logic [id_width_p-1:0]     nasti_ar_id_i,
  input  logic [addr_width_p-1:0]   nasti_ar_addr_i,
  input  logic [len_width_p-1:0]    nasti_ar_len_i,
  input  logic [1:0]                nasti_ar_burst_i,
  output logic                      nasti_ar_ready_o,
  input  logic                      nasti_aw_valid_i,
  input  logic [id_width_p-1:0]     nasti_aw_id_i,
  input  logic [addr_width_p-1:0]   nasti_aw_addr_i,
  input  logic [len_width_p-1:0]    nasti_aw_len_i,
  input  logic [1:0]                nasti_aw_burst_i,
  output logic                      nasti_aw_ready_o,
  input  logic                      nasti_w_valid_i,
  input  logic [data_width_p-1:0]   nasti_w_data_i,
  input  logic [data_width_p/8-1:0] nasti_w_strb_i,
  input  logic                      nasti_w_last_i,
  output logic                      nasti_w_ready_o,
  output logic                      nasti_b_valid_o,
  output logic [id_width_p-1:0]     nasti_b_id_o,
  output logic [1:0]                nasti_b_resp_o,
  input  logic                      nasti_b_ready_i,
  output logic                      req_v_o,
  output logic [req_width(id_width_p, addr_width_p, data_width_p)-1:0]
                                    req_data_o,
  input  logic                      req_yumi_i,
  output logic                      burst_err_o
);

  state_e state, state_n;
  logic   prio_write;
  logic [id_width_p-1:0] id_r;

  logic                      ld, step, beat_last, wr;
  logic [addr_width_p-1:0]   ld_addr, addr;
  logic [len_width_p-1:0]    ld_len, count;
  logic [1:0]                ld_burst;
  logic [data_width_p-1:0]   data;
  logic [data_width_p/8-1:0] mask;

  assign ld       = nasti_ar_ready_o | nasti_aw_ready_o;
  assign ld_addr  = nasti_ar_ready_o ? nasti_ar_addr_i  : nasti_aw_addr_i;
  assign ld_len   = nasti_ar_ready_o ? nasti_ar_len_i   : nasti_aw_len_i;
  assign ld_burst = nasti_ar_ready_o ? nasti_ar_burst_i : nasti_aw_burst_i;

  bsg_nasti_burst_addr_gen #(
    .addr_width_p (addr_width_p),
    .len_width_p  (len_width_p),
    .data_width_p (data_width_p)
  ) u_agen (
    .clk        (clk_i),
    .rst_n      (reset_n_i),
    .load       (ld),
    .step       (step),
    .load_addr  (ld_addr),
    .load_len   (ld_len),
    .load_burst (ld_burst),
    .addr       (addr),
    .count      (count),
    .last       (beat_last)
  );

  always_comb begin
    state_n          = state;
    nasti_ar_ready_o = 1'b0;
    nasti_aw_ready_o = 1'b0;
    nasti_w_ready_o  = 1'b0;
    nasti_b_valid_o  = 1'b0;
    req_v_o          = 1'b0;
    step             = 1'b0;
    wr               = 1'b0;
    data             = '0;
    mask             = '0;
    unique case (state)
      S_IDLE: begin
        // a tie goes to whichever side holds priority
        nasti_ar_ready_o = reset_n_i & nasti_ar_valid_i
                         & (~nasti_aw_valid_i | ~prio_write);
        nasti_aw_ready_o = reset_n_i & nasti_aw_valid_i
                         & (~nasti_ar_valid_i | prio_write);
        if (nasti_ar_ready_o)
          state_n = S_READ;
        else if (nasti_aw_ready_o)
          state_n = S_WRITE;
      end
      S_READ: begin
        req_v_o = 1'b1;
        step    = req_yumi_i;
        if (req_yumi_i && beat_last)
          state_n = S_IDLE;
      end
      S_WRITE: begin
        req_v_o         = nasti_w_valid_i;
        wr              = 1'b1;
        data            = nasti_w_data_i;
        mask            = nasti_w_strb_i;
        nasti_w_ready_o = req_yumi_i;
        step            = req_yumi_i;
        if (req_yumi_i && beat_last)
          state_n = S_WRESP;
      end
      S_WRESP: begin
        nasti_b_valid_o = 1'b1;
        if (nasti_b_ready_i)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= S_IDLE;
      prio_write  <= 1'b0;
      id_r        <= '0;
      burst_err_o <= 1'b0;
    end else begin
      state <= state_n;
      if (ld) begin
        prio_write <= ~prio_write;
        id_r <= nasti_ar_ready_o ? nasti_ar_id_i : nasti_aw_id_i;
      end
      // beat count wins; a misplaced wlast is only flagged
      if (state == S_WRITE && req_yumi_i
          && (nasti_w_last_i != beat_last))
        burst_err_o <= 1'b1;
    end
  end

  assign nasti_b_id_o   = id_r;
  assign nasti_b_resp_o = RESP_OKAY;
  assign req_data_o     = {wr, id_r, addr, data, mask, beat_last};

endmodule
